// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package inst_fetch_buf_pkg;
    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int InstAddrBusW = 32;
    localparam int InstBusW     = 32;

    typedef logic [InstAddrBusW-1:0] inst_addr_t;
    typedef logic [InstBusW-1:0]     inst_t;

    // One prefetch FIFO entry: the word together with the PC it came from.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_entry_t;

    localparam inst_addr_t RESET_PC_DEF = 32'h0000_0000;

    function automatic inst_addr_t align_word(input inst_addr_t a);
        return a & ~inst_addr_t'(3);
    endfunction
endpackage

// File: rtl/inst_fetch_buf_fifo.sv
// Generic synchronous FIFO (power-of-2 depth) with push/pop/flush and occupancy count.
module ifetch_fifo
    import inst_fetch_buf_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstDisable && push_i && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    // The parent's issue throttle must never let a return land on a full FIFO.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push_i && !flush_i && count_q == FULL && !do_pop));
endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction-fetch front end: PC generation, ROM issue, prefetch buffering, redirect.
// Optional perf counters are enabled with the IFETCH_PERF_EN macro.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_PC_DEF,
    parameter int         DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    inst_addr_t   pc_q, pc_d, inflight_pc_q;
    logic         inflight_q;
    logic [CW-1:0] count;
    logic [CW:0]  occupancy;
    logic         issue, push, pop;
    fetch_entry_t head, entry_in;

    // Credit counts the in-flight word but not a same-cycle pop.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue     = (rst == RstDisable) && !branch_flag && (occupancy < DEPTH_W);
    assign rom_ce    = issue ? ChipEnable : ChipDisable;
    assign rom_addr  = (rst == RstEnable) ? '0 : pc_q;

    assign push      = inflight_q && !branch_flag;
    assign if_valid  = (count != '0);
    assign pop       = if_valid && !stall && !branch_flag;
    assign if_pc     = if_valid ? head.pc   : '0;
    assign if_inst   = if_valid ? head.inst : '0;

    assign entry_in.pc   = inflight_pc_q;
    assign entry_in.inst = rom_data;

    always_comb begin
        pc_d = pc_q;
        if (branch_flag)  pc_d = align_word(branch_target);
        else if (issue)   pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
        end
    end

    ifetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (entry_in),
        .pop_i   (pop),
        .flush_i (branch_flag),
        .dout_o  (head),
        .count_o (count)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (issue && fetch_cnt_q != '1)       fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (branch_flag && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: queue-based reference model plus directed literals.
module tb_inst_fetch_buf;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, rom_ce, if_valid;
    logic [31:0] branch_target, rom_addr, if_pc, if_inst;
    logic [31:0] rom_data = 32'h0;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    inst_fetch_buf #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .stall         (stall),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word is the bitwise inverse of its address.
    always @(posedge clk) if (rom_ce) rom_data <= ~rom_addr;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffered PCs in a queue, one pending ROM return, next PC.
    logic [31:0] mq[$];
    bit          m_init = 0;
    bit          m_pend = 0;
    logic [31:0] m_pc = 32'h0, m_ppc = 32'h0;
    logic [31:0] m_fetch = 32'h0, m_flush = 32'h0;

    function automatic bit m_issue();
        return !rst && !branch_flag && ((mq.size() + int'(m_pend)) < DEPTH);
    endfunction

    always @(posedge clk) begin
        bit iss;
        if (rst) begin
            m_init = 1; m_pc = RPC; mq.delete(); m_pend = 0;
            m_fetch = 32'h0; m_flush = 32'h0;
        end else begin
            iss = m_issue();
            if (iss) m_fetch = m_fetch + 32'd1;
            if (branch_flag) begin
                m_flush = m_flush + 32'd1;
                mq.delete();
                m_pend = 0;
                m_pc = branch_target & 32'hFFFF_FFFC;
            end else begin
                if (mq.size() != 0 && !stall) void'(mq.pop_front());
                if (m_pend) mq.push_back(m_ppc);
                if (mq.size() > DEPTH) begin
                    tests++; fails++;
                    $display("FAIL model_overflow: size %0d limit %0d", mq.size(), DEPTH);
                end
                m_pend = iss;
                if (iss) begin
                    m_ppc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (m_init) begin
            chk1("rom_ce", rom_ce, m_issue());
            if (rst) chk32("rom_addr_rst", rom_addr, 32'h0);
            else if (m_issue()) chk32("rom_addr", rom_addr, m_pc);
            chk1("if_valid", if_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk32("if_pc", if_pc, mq[0]);
                chk32("if_inst", if_inst, ~mq[0]);
            end else begin
                chk32("if_pc_idle", if_pc, 32'h0);
                chk32("if_inst_idle", if_inst, 32'h0);
            end
`ifdef IFETCH_PERF_EN
            chk32("perf_fetch", perf_fetch_cnt, m_fetch);
            chk32("perf_flush", perf_flush_cnt, m_flush);
`endif
        end
    end

    task automatic cyc(input bit r, input bit s, input bit b, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; branch_flag = b; branch_target = t;
        #3;
    endtask

    initial begin
        int n;
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;

        // Reset and first-fetch latency
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk1("rst_valid", if_valid, 1'b0);
        chk1("rst_ce", rom_ce, 1'b0);
        chk32("rst_addr", rom_addr, 32'h0);
        cyc(0, 0, 0, 0);
        chk1("first_ce", rom_ce, 1'b1);
        chk32("first_addr", rom_addr, 32'h0);
        cyc(0, 0, 0, 0);
        chk32("second_addr", rom_addr, 32'h4);
        chk1("lat_not_valid", if_valid, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("first_valid", if_valid, 1'b1);
        chk32("first_pc", if_pc, 32'h0);
        chk32("first_inst", if_inst, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0);
        chk32("next_pc", if_pc, 32'h4);

        // Stall from first valid: fill to DEPTH, then drain in order
        cyc(1, 0, 0, 0);
        n = 0;
        cyc(0, 0, 0, 0); n += int'(rom_ce);
        cyc(0, 0, 0, 0); n += int'(rom_ce);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0); n += int'(rom_ce);
        end
        chk32("stall_fetches", 32'(n), 32'd4);
        chk32("stall_head", if_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk32("drain_pc", if_pc, 32'(i * 4));
        end

        // Branch with an in-flight return pending
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk32("pre_br_addr", rom_addr, 32'h8);
        cyc(0, 0, 1, 32'h100);
        chk1("br_no_issue", rom_ce, 1'b0);
        cyc(0, 0, 0, 0);
        chk32("br_tgt_addr", rom_addr, 32'h100);
        chk1("br_flushed", if_valid, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("br_killed", if_valid, 1'b0);
        cyc(0, 0, 0, 0);
        chk32("br_first_pc", if_pc, 32'h100);

        // Misaligned target is word-aligned
        cyc(0, 0, 1, 32'h103);
        cyc(0, 0, 0, 0);
        chk32("br_align", rom_addr, 32'h100);

        // Branch beats stall on a full FIFO
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0);
        chk1("full_valid", if_valid, 1'b1);
        cyc(0, 1, 1, 32'h200);
        cyc(0, 1, 0, 0);
        chk1("full_flushed", if_valid, 1'b0);
        chk32("full_tgt", rom_addr, 32'h200);

        // Mid-stream reset
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk1("midrst_ce", rom_ce, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("midrst_valid", if_valid, 1'b0);
        chk32("midrst_addr", rom_addr, RPC);

        // PC wrap
        cyc(0, 0, 1, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0); chk32("wrap_a0", rom_addr, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0); chk32("wrap_a1", rom_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0); chk32("wrap_a2", rom_addr, 32'h0);
        chk32("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0); chk32("wrap_pc1", if_pc, 32'hFFFF_FFFC);

        // Back-to-back branches: last target wins
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h20);
        cyc(0, 0, 1, 32'h40);
        cyc(0, 1, 0, 0);
        chk32("b2b_addr", rom_addr, 32'h40);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
`ifdef IFETCH_PERF_EN
        chk32("perf_fetch_lit", perf_fetch_cnt, 32'd4);
        chk32("perf_flush_lit", perf_flush_cnt, 32'd2);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk32("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        chk32("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 40,
                $urandom_range(0, 99) < 6,
                $urandom);
        end

        cyc(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
